// File: rtl/hyperbus_native_responder.sv
// ---------------------------------------------------------------------------
// hyperbus_native_responder
//
// Memory-side responder for the Hyperbus native interface. It accepts
// read/write requests on the rising edge of (hbus_rrq | hbus_wrq), holds
// hbus_busy through a fixed initial latency, then streams a fixed-length
// burst of words to or from an internal word-addressed memory. It is a
// synthesizable stand-in for a Hyperbus controller/PHY.
//
// Parameters:
//   HBUS_ADDR_WIDTH  request address width
//   HBUS_DATA_WIDTH  bus word width
//   MEM_ADDR_WIDTH   log2 of memory depth in words (low address bits only)
//   LATENCY          busy-only cycles before the first beat (0..255)
//   BURST            words per request (1..255)
//
// Ports:
//   hbus_clk    sole clock
//   hbus_rst_n  asynchronous active-low reset
//   hbus_adr_i  request word address
//   hbus_rrq    read request (level; rising edge starts a request)
//   hbus_wrq    write request (level; rising edge starts a request)
//   hbus_dat_i  write data, sampled in cycles where hbus_ready is high
//   hbus_dat_o  read data, valid when hbus_valid is high, zero otherwise
//   hbus_ready  write beat this cycle
//   hbus_valid  read beat this cycle
//   hbus_busy   transaction in progress
//   overrun     sticky flag: a request edge was dropped
//
// Optional build macro:
//   HYPERBUS_RESP_STALL_EN  when defined, one stall cycle is inserted after
//                           every 4th beat of a burst if more beats remain.
//
// All outputs are registered. They are loaded from the next-state values so
// that each output describes the cycle the state register is entering.
// ---------------------------------------------------------------------------
module hyperbus_native_responder #(
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int MEM_ADDR_WIDTH  = 8,
    parameter int LATENCY         = 6,
    parameter int BURST           = 2
) (
    input  logic                       hbus_clk,
    input  logic                       hbus_rst_n,
    input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
    input  logic                       hbus_rrq,
    input  logic                       hbus_wrq,
    input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
    output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
    output logic                       hbus_ready,
    output logic                       hbus_valid,
    output logic                       hbus_busy,
    output logic                       overrun
);

    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LAT   = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
`ifdef HYPERBUS_RESP_STALL_EN
    localparam logic [1:0] ST_STALL = 2'd3;
`endif

    localparam logic [7:0] LAT_INIT   = 8'(LATENCY);
    localparam logic [7:0] BURST_INIT = 8'(BURST);

    // Word memory; deliberately not reset.
    logic [HBUS_DATA_WIDTH-1:0] mem [DEPTH];

    // Current state
    logic [1:0]                state;
    logic [7:0]                lat_cnt;
    logic [7:0]                beat_cnt;
    logic [MEM_ADDR_WIDTH-1:0] adr;
    logic                      rd;
    logic                      req_q;
    logic                      pend_v;
    logic                      pend_rd;
    logic [MEM_ADDR_WIDTH-1:0] pend_adr;
`ifdef HYPERBUS_RESP_STALL_EN
    logic [1:0]                sub_cnt;
`endif

    // Next state
    logic [1:0]                nxt_state;
    logic [7:0]                nxt_lat;
    logic [7:0]                nxt_beat;
    logic [MEM_ADDR_WIDTH-1:0] nxt_adr;
    logic                      nxt_rd;
    logic                      nxt_pend_v;
    logic                      nxt_pend_rd;
    logic [MEM_ADDR_WIDTH-1:0] nxt_pend_adr;
    logic                      nxt_overrun;
`ifdef HYPERBUS_RESP_STALL_EN
    logic [1:0]                nxt_sub;
`endif

    // Request edge decode
    logic                      req;
    logic                      is_edge;
    logic                      edge_rd;
    logic [MEM_ADDR_WIDTH-1:0] edge_adr;

    // Upper address bits are intentionally ignored.
    logic                      unused_adr;

    assign unused_adr = ^hbus_adr_i;

    assign req      = hbus_rrq | hbus_wrq;
    assign is_edge  = req & ~req_q;
    assign edge_rd  = hbus_rrq;              // read wins when both rise together
    assign edge_adr = hbus_adr_i[MEM_ADDR_WIDTH-1:0];

    always_comb begin
        nxt_state    = state;
        nxt_lat      = lat_cnt;
        nxt_beat     = beat_cnt;
        nxt_adr      = adr;
        nxt_rd       = rd;
        nxt_pend_v   = pend_v;
        nxt_pend_rd  = pend_rd;
        nxt_pend_adr = pend_adr;
        nxt_overrun  = overrun;
`ifdef HYPERBUS_RESP_STALL_EN
        nxt_sub      = sub_cnt;
`endif

        case (state)
            ST_IDLE: begin
                if (pend_v || is_edge) begin
                    // A waiting request is serviced first; a fresh edge in the
                    // same cycle refills the slot that has just been emptied.
                    nxt_rd    = pend_v ? pend_rd  : edge_rd;
                    nxt_adr   = pend_v ? pend_adr : edge_adr;
                    nxt_lat   = LAT_INIT;
                    nxt_beat  = BURST_INIT;
                    nxt_state = (LATENCY == 0) ? ST_XFER : ST_LAT;
`ifdef HYPERBUS_RESP_STALL_EN
                    nxt_sub   = 2'd0;
`endif
                    if (pend_v) begin
                        nxt_pend_v   = is_edge;
                        nxt_pend_rd  = edge_rd;
                        nxt_pend_adr = edge_adr;
                    end
                end
            end

            ST_LAT: begin
                nxt_lat = lat_cnt - 8'd1;
                if (lat_cnt == 8'd1) begin
                    nxt_state = ST_XFER;
                end
            end

            ST_XFER: begin
                nxt_adr  = adr + 1'b1;       // wraps at the top of memory
                nxt_beat = beat_cnt - 8'd1;
`ifdef HYPERBUS_RESP_STALL_EN
                nxt_sub  = sub_cnt + 2'd1;
`endif
                if (beat_cnt == 8'd1) begin
                    nxt_state = ST_IDLE;
`ifdef HYPERBUS_RESP_STALL_EN
                end else if (sub_cnt == 2'd3) begin
                    nxt_state = ST_STALL;
`endif
                end
            end

`ifdef HYPERBUS_RESP_STALL_EN
            ST_STALL: begin
                nxt_state = ST_XFER;
            end
`endif

            default: begin
                nxt_state = ST_IDLE;
            end
        endcase

        // Edges while a transaction runs go to the one-deep slot, or are
        // dropped if it is already occupied.
        if (state != ST_IDLE && is_edge) begin
            if (pend_v) begin
                nxt_overrun = 1'b1;
            end else begin
                nxt_pend_v   = 1'b1;
                nxt_pend_rd  = edge_rd;
                nxt_pend_adr = edge_adr;
            end
        end
    end

    always_ff @(posedge hbus_clk or negedge hbus_rst_n) begin
        if (!hbus_rst_n) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            beat_cnt   <= '0;
            adr        <= '0;
            rd         <= 1'b0;
            req_q      <= 1'b0;
            pend_v     <= 1'b0;
            pend_rd    <= 1'b0;
            pend_adr   <= '0;
            overrun    <= 1'b0;
            hbus_busy  <= 1'b0;
            hbus_valid <= 1'b0;
            hbus_ready <= 1'b0;
            hbus_dat_o <= '0;
`ifdef HYPERBUS_RESP_STALL_EN
            sub_cnt    <= '0;
`endif
        end else begin
            state      <= nxt_state;
            lat_cnt    <= nxt_lat;
            beat_cnt   <= nxt_beat;
            adr        <= nxt_adr;
            rd         <= nxt_rd;
            req_q      <= req;
            pend_v     <= nxt_pend_v;
            pend_rd    <= nxt_pend_rd;
            pend_adr   <= nxt_pend_adr;
            overrun    <= nxt_overrun;
            hbus_busy  <= (nxt_state != ST_IDLE);
            hbus_valid <= (nxt_state == ST_XFER) && nxt_rd;
            hbus_ready <= (nxt_state == ST_XFER) && !nxt_rd;
            hbus_dat_o <= ((nxt_state == ST_XFER) && nxt_rd) ? mem[nxt_adr] : '0;
`ifdef HYPERBUS_RESP_STALL_EN
            sub_cnt    <= nxt_sub;
`endif
        end
    end

    // Write beat: hbus_ready marks the cycle whose hbus_dat_i is stored at
    // the current address. Reset forces hbus_ready low, so no write happens.
    always_ff @(posedge hbus_clk) begin
        if (hbus_ready) begin
            mem[adr] <= hbus_dat_i;
        end
    end

endmodule
